// File: rtl/uart_transmitter_if.sv
// Byte-wide valid/ready handshake feeding the UART transmitter.
// The producer (master) offers in_data/in_valid; the transmitter (slave) answers with in_ready.
interface uart_transmitter_if;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;

   modport master (output in_data, output in_valid, input in_ready);
   modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter: one-entry holding register in front of a shift register,
// so the next byte can be queued while the current frame is on the line.
module uart_transmitter #(
   parameter int unsigned SEND_INTERVAL = 10000,
   parameter int unsigned STOP_BITS     = 1
) (
   input  logic                clk,
   input  logic                reset,
   uart_transmitter_if.slave   in_if,
   output logic                uart_tx,
   output logic                busy
);

   generate
      if (SEND_INTERVAL < 2) begin : g_bad_interval
         $error("uart_transmitter: SEND_INTERVAL must be >= 2");
      end
      if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
         $error("uart_transmitter: STOP_BITS must be 1 or 2");
      end
   endgenerate

   localparam logic [31:0] INTERVAL  = 32'(SEND_INTERVAL);
   localparam logic [2:0]  LAST_STOP = 3'(STOP_BITS - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t      state, state_next;
   logic [31:0] clock_count;
   logic [2:0]  bit_count, bit_next;
   logic [7:0]  hold_data;
   logic [7:0]  shift;
   logic        hold_full;
   logic        tx_next;
   logic        load_shift;
   logic        bit_boundary;
   logic        interval_done;
   logic        last_bit;
   logic        last_stop;
   logic        accept;

   assign interval_done = !(clock_count + 32'd1 < INTERVAL);
   assign last_bit      = (bit_count == 3'd7);
   assign last_stop     = (bit_count == LAST_STOP);
   assign in_if.in_ready = !hold_full;
   assign accept        = in_if.in_valid && !hold_full;
   assign busy          = (state != IDLE) || hold_full;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:  if (hold_full) state_next = START;
         START: if (interval_done) state_next = DATA;
         DATA:  if (interval_done && last_bit) state_next = STOP;
         STOP:  if (interval_done && last_stop) state_next = hold_full ? START : IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Registered-output controls: uart_tx is always updated from tx_next, so it only moves at bit boundaries.
   always_comb begin
      tx_next      = uart_tx;
      load_shift   = 1'b0;
      bit_boundary = 1'b0;
      bit_next     = bit_count;
      case (state)
         IDLE: begin
            tx_next = 1'b1;
            if (hold_full) begin
               load_shift   = 1'b1;
               bit_boundary = 1'b1;
               bit_next     = 3'd0;
               tx_next      = 1'b0;
            end
         end
         START: begin
            if (interval_done) begin
               bit_boundary = 1'b1;
               bit_next     = 3'd0;
               tx_next      = shift[0];
            end
         end
         DATA: begin
            if (interval_done) begin
               bit_boundary = 1'b1;
               if (last_bit) begin
                  bit_next = 3'd0;
                  tx_next  = 1'b1;
               end else begin
                  bit_next = bit_count + 3'd1;
                  tx_next  = shift[bit_count + 3'd1];
               end
            end
         end
         STOP: begin
            if (interval_done) begin
               bit_boundary = 1'b1;
               if (!last_stop) begin
                  bit_next = bit_count + 3'd1;
                  tx_next  = 1'b1;
               end else if (hold_full) begin
                  load_shift = 1'b1;
                  bit_next   = 3'd0;
                  tx_next    = 1'b0;
               end else begin
                  bit_next = 3'd0;
                  tx_next  = 1'b1;
               end
            end
         end
         default: tx_next = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         uart_tx     <= 1'b1;
         clock_count <= '0;
         bit_count   <= '0;
         shift       <= '0;
         hold_data   <= '0;
         hold_full   <= 1'b0;
      end else begin
         uart_tx   <= tx_next;
         bit_count <= bit_next;
         if (bit_boundary)        clock_count <= '0;
         else if (state != IDLE)  clock_count <= clock_count + 32'd1;
         if (load_shift) shift <= hold_data;
         // accept needs an empty holder and load_shift a full one, so they never coincide
         if (accept) begin
            hold_data <= in_if.in_data;
            hold_full <= 1'b1;
         end else if (load_shift) begin
            hold_full <= 1'b0;
         end
      end
   end

endmodule
